credit_sender: RTL and testbench

Transmitter end of the credit-based link into a remote `queue`. Accepts a `decoupled` stream locally and drives a valid-only registered output toward a receiver `queue` of known depth. Tracks free receiver slots with a credit counter, so the receiver's `enq.ready` never needs to cross back. Credits return one per receiver dequeue. Sits between a pipeline stage and a distant buffer, e.g. a decode-to-issue link, where a long combinational ready path is unacceptable.

---
 rtl/credit_sender.sv | 87 ++++++++
 tb/tb_credit_sender.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/credit_sender.sv
// credit_sender: transmit end of a credit-based link into a remote queue.
// A local credit counter mirrors the free slots of the receiver queue, so the
// receiver's enqueue ready never has to travel back to this side. The output
// is a registered valid-only beat that the receiver is obliged to accept.
module credit_sender #(
   parameter  int DW      = 32,                 // payload width (receiver queue data)
   parameter  int CREDITS = 2,                  // receiver usable capacity, 1..255
   localparam int CW      = $clog2(CREDITS + 1) // credit counter width
) (
   input  logic          clk,
   input  logic          rst,
   // local producer stream
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_data,
   // link toward the receiver queue
   output logic          out_valid,
   output logic [DW-1:0] out_data,
   input  logic          credit_ret,
   input  logic          flush,
   // status
   output logic [CW-1:0] credits,
   output logic          idle,
   output logic          err
);

   localparam logic [CW-1:0] FULL = CW'(CREDITS);

   logic          accept;
   logic [CW-1:0] credits_nxt;
   logic          err_nxt;

   // Ready comes only from registered credits and flush: no path from
   // credit_ret or in_valid, which keeps the producer-side ready short.
   assign in_ready = (credits != '0) && !flush;
   assign accept   = in_valid && in_ready;
   assign idle     = (credits == FULL) && !out_valid;

   // Next credit count and sticky overflow flag; flush wins over everything.
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path
      // leaves it unassigned and no latch is inferred.
      credits_nxt = credits;
      err_nxt     = err;
      if (flush) begin
         // A credit returned in the flush cycle is discarded on purpose: the
         // receiver is flushed in the same cycle and restarts empty.
         credits_nxt = FULL;
      end else if (accept && !credit_ret) begin
         credits_nxt = credits - 1'b1;
      end else if (!accept && credit_ret) begin
         if (credits == FULL) begin
            // Receiver returned a credit it never had: saturate and flag.
            err_nxt = 1'b1;
         end else begin
            credits_nxt = credits + 1'b1;
         end
      end
   end

   // Credit counter and error flag registers.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values regardless of statement order.
      if (rst) begin
         credits <= FULL;
         err     <= 1'b0;
      end else begin
         credits <= credits_nxt;
         err     <= err_nxt;
      end
   end

   // Output beat: one cycle of valid per accept; data holds between beats.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
      end else begin
         out_valid <= accept;
         if (accept) begin
            out_data <= in_data;
         end
      end
   end

endmodule

// File: tb/tb_credit_sender.sv
// Directed and loopback bench for credit_sender with CREDITS=2.
// Inputs are driven and outputs sampled at the falling clock edge.
module tb_credit_sender;

   localparam int DW      = 32;
   localparam int CREDITS = 2;
   localparam int CW      = $clog2(CREDITS + 1);

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_data;
   logic          out_valid;
   logic [DW-1:0] out_data;
   logic          credit_ret;
   logic          flush;
   logic [CW-1:0] credits;
   logic          idle;
   logic          err;

   int checks = 0;
   int errors = 0;

   credit_sender #(.DW(DW), .CREDITS(CREDITS)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .credit_ret (credit_ret),
      .flush      (flush),
      .credits    (credits),
      .idle       (idle),
      .err        (err)
   );

   always #5 clk = ~clk;

   // Advance one clock: through the rising edge to the next falling edge.
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; in_data = '0; credit_ret = 1'b0; flush = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
      checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data got %h exp 0", out_data); end
      checks++; if (credits !== 2'd2) begin errors++; $display("FAIL reset_credits got %0d exp 2", credits); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err); end
      checks++; if (idle !== 1'b1) begin errors++; $display("FAIL reset_idle got %b exp 1", idle); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
      @(negedge clk);
   endtask

   // Hold in_valid from reset: two accepts, then credits run out.
   task automatic test_fill();
      in_valid = 1'b1; in_data = 32'hA;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fill_ready0 got %b exp 1", in_ready); end
      tick();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL fill_valid1 got %b exp 1", out_valid); end
      checks++; if (out_data !== 32'hA) begin errors++; $display("FAIL fill_data1 got %h exp a", out_data); end
      checks++; if (credits !== 2'd1) begin errors++; $display("FAIL fill_credits1 got %0d exp 1", credits); end
      in_data = 32'hB;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fill_ready1 got %b exp 1", in_ready); end
      tick();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL fill_valid2 got %b exp 1", out_valid); end
      checks++; if (out_data !== 32'hB) begin errors++; $display("FAIL fill_data2 got %h exp b", out_data); end
      checks++; if (credits !== 2'd0) begin errors++; $display("FAIL fill_credits2 got %0d exp 0", credits); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_ready2 got %b exp 0", in_ready); end
      in_data = 32'hC;
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fill_valid3 got %b exp 0", out_valid); end
      checks++; if (out_data !== 32'hB) begin errors++; $display("FAIL fill_hold3 got %h exp b", out_data); end
      checks++; if (credits !== 2'd0) begin errors++; $display("FAIL fill_credits3 got %0d exp 0", credits); end
   endtask

   // Credits at 0: a returned credit raises ready only in the next cycle.
   task automatic test_credit_return();
      in_valid = 1'b1; in_data = 32'hD; credit_ret = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL ret_ready_same got %b exp 0", in_ready); end
      tick();
      credit_ret = 1'b0;
      #1;
      checks++; if (credits !== 2'd1) begin errors++; $display("FAIL ret_credits got %0d exp 1", credits); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ret_ready_next got %b exp 1", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ret_no_beat got %b exp 0", out_valid); end
      tick();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ret_beat got %b exp 1", out_valid); end
      checks++; if (out_data !== 32'hD) begin errors++; $display("FAIL ret_data got %h exp d", out_data); end
      checks++; if (credits !== 2'd0) begin errors++; $display("FAIL ret_credits0 got %0d exp 0", credits); end
      in_valid = 1'b0;
   endtask

   // credits=1 with accept and credit_ret together for 10 cycles.
   task automatic test_back_to_back();
      int beats = 0;
      credit_ret = 1'b1;
      tick();
      checks++; if (credits !== 2'd1) begin errors++; $display("FAIL b2b_start got %0d exp 1", credits); end
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'b1; in_data = 32'h100 + i; credit_ret = 1'b1;
         tick();
         if (out_valid === 1'b1) beats++;
         checks++; if (out_data !== 32'h100 + i) begin errors++; $display("FAIL b2b_data[%0d] got %h exp %h", i, out_data, 32'h100 + i); end
         checks++; if (credits !== 2'd1) begin errors++; $display("FAIL b2b_credits[%0d] got %0d exp 1", i, credits); end
      end
      checks++; if (beats != 10) begin errors++; $display("FAIL b2b_beats got %0d exp 10", beats); end
      in_valid = 1'b0; credit_ret = 1'b1;
      tick();
      credit_ret = 1'b0;
      checks++; if (credits !== 2'd2) begin errors++; $display("FAIL b2b_refill got %0d exp 2", credits); end
   endtask

   // Extra credit while full: saturate and set sticky err, which survives flush.
   task automatic test_overflow();
      tick();
      checks++; if (idle !== 1'b1) begin errors++; $display("FAIL ovf_idle got %b exp 1", idle); end
      credit_ret = 1'b1;
      tick();
      credit_ret = 1'b0;
      checks++; if (credits !== 2'd2) begin errors++; $display("FAIL ovf_credits got %0d exp 2", credits); end
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL ovf_err got %b exp 1", err); end
      flush = 1'b1;
      tick();
      flush = 1'b0;
      tick();
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL ovf_err_flush got %b exp 1", err); end
   endtask

   // Flush at credits=0 with a beat in flight, plus in_valid and credit_ret.
   task automatic test_flush();
      in_valid = 1'b1; in_data = 32'h55;
      tick();
      in_data = 32'h66;
      tick();
      checks++; if (credits !== 2'd0 || out_valid !== 1'b1) begin errors++; $display("FAIL flush_setup credits %0d valid %b exp 0 1", credits, out_valid); end
      flush = 1'b1; credit_ret = 1'b1; in_data = 32'h77;
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_ready got %b exp 0", in_ready); end
      tick();
      flush = 1'b0; credit_ret = 1'b0; in_valid = 1'b0;
      #1;
      checks++; if (credits !== 2'd2) begin errors++; $display("FAIL flush_credits got %0d exp 2", credits); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %b exp 0", out_valid); end
      checks++; if (idle !== 1'b1) begin errors++; $display("FAIL flush_idle got %b exp 1", idle); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_ready_next got %b exp 1", in_ready); end
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL flush_err got %b exp 1", err); end
      @(negedge clk);
   endtask

   // Asynchronous reset mid-transfer drops the beat and clears err.
   task automatic test_reset_clear();
      in_valid = 1'b1; in_data = 32'h99;
      tick();
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rst_setup got %b exp 1", out_valid); end
      #1 rst = 1'b1;
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_drop got %b exp 0", out_valid); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err got %b exp 0", err); end
      checks++; if (credits !== 2'd2) begin errors++; $display("FAIL rst_credits got %0d exp 2", credits); end
      tick();
      rst = 1'b0;
      @(negedge clk);
   endtask

   // Random loopback into a 2-entry receiver queue model (DEPTH=3).
   task automatic test_loopback();
      logic [DW-1:0] q[$];
      logic [DW-1:0] tx_cnt = '0;
      logic [DW-1:0] rx_cnt = '0;
      logic          deq_prev = 1'b0;
      logic          deq;
      for (int cyc = 0; cyc < 10000; cyc++) begin
         // receiver side for this cycle, state as of its start
         if (out_valid === 1'b1) begin
            checks++; if (q.size() >= 2) begin errors++; $display("FAIL loop_enq_ready cycle %0d size %0d exp <2", cyc, q.size()); end
         end
         deq = (q.size() > 0) && ($urandom_range(0, 1) == 1);
         if (deq) begin
            logic [DW-1:0] v = q.pop_front();
            checks++; if (v !== rx_cnt) begin errors++; $display("FAIL loop_order cycle %0d got %h exp %h", cyc, v, rx_cnt); end
            rx_cnt++;
         end
         if (out_valid === 1'b1) q.push_back(out_data);
         // sender-side stimulus for this cycle
         credit_ret = deq_prev;
         deq_prev   = deq;
         in_valid   = ($urandom_range(0, 2) != 0);
         in_data    = tx_cnt;
         #1;
         if (in_valid && in_ready) tx_cnt++;
         tick();
      end
      in_valid = 1'b0; credit_ret = 1'b0;
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL loop_err got %b exp 0", err); end
      checks++; if (rx_cnt < 32'd1000) begin errors++; $display("FAIL loop_progress got %0d exp >=1000", rx_cnt); end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_fill();
      test_credit_return();
      test_back_to_back();
      test_overflow();
      test_flush();
      test_reset_clear();
      test_loopback();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
